// File: rtl/dlfloat16_vec_acc.sv
// Sums a DLFloat16 vector via an external dlfloat16_add; 1 elem/cycle, result 1 cycle (single) / 2 cycles (multi) after last.
// Backpressure: in_ready drops in FLUSH and HOLD; HOLD keeps the result until out_ready.
module dlfloat16_vec_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {EMPTY, ACC, FLUSH, HOLD} state_t;

  state_t           state;
  logic [15:0]      acc_q;
  logic [15:0]      opnd_q;
  logic             opnd_vld;
  logic [CNT_W-1:0] cnt_q;
  logic             in_hs;
  logic             out_hs;

  assign in_ready  = (state == EMPTY) || (state == ACC);
  assign out_valid = (state == HOLD);
  assign in_hs     = in_valid && in_ready && !flush;
  assign out_hs    = out_valid && out_ready && !flush;

  assign add_a     = acc_q;
  assign add_b     = opnd_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      acc_q    <= '0;
      opnd_q   <= '0;
      opnd_vld <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      cnt_q    <= '0;
      opnd_vld <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          // The adder mishandles zero-exponent operands, so the first element seeds acc_q directly.
          if (in_hs) begin
            acc_q <= in_data;
            cnt_q <= CNT_W'(1);
            state <= in_last ? HOLD : ACC;
          end
        end
        ACC: begin
          if (opnd_vld) begin
            acc_q    <= add_sum;
            opnd_vld <= 1'b0;
          end
          if (in_hs) begin
            opnd_q   <= in_data;
            opnd_vld <= 1'b1;
            cnt_q    <= (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            if (in_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          acc_q    <= add_sum;
          opnd_vld <= 1'b0;
          state    <= HOLD;
        end
        HOLD: begin
          if (out_hs) begin
            state    <= EMPTY;
            cnt_q    <= '0;
            opnd_vld <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat16_vec_acc.sv
// Directed bench: two accumulators (CNT_W=8 and CNT_W=2) share stimulus, each wired to a DLFloat16 adder.
module tb_dlfloat16_vec_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [15:0] add_a, add_b, add_sum, out_data;
  logic [7:0]  out_count;

  logic        in_ready2, out_valid2;
  logic [15:0] add_a2, add_b2, add_sum2, out_data2;
  logic [1:0]  out_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Adder: normal operands, truncating alignment; exact for the small integers used here.
  function automatic logic [15:0] dl_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    int          ex, ey, d;
    logic [13:0] mx, my, s;
    x = a;
    y = b;
    if (y[14:0] > x[14:0]) begin
      t = x; x = y; y = t;
    end
    ex = int'(x[14:9]);
    ey = int'(y[14:9]);
    mx = (ex == 0) ? 14'd0 : {2'b01, x[8:0], 3'b000};
    my = (ey == 0) ? 14'd0 : {2'b01, y[8:0], 3'b000};
    d  = ex - ey;
    my = (d > 13) ? 14'd0 : (my >> d);
    s  = (x[15] == y[15]) ? (mx + my) : (mx - my);
    if (s == 14'd0) return 16'h0000;
    if (s[13]) begin
      s  = s >> 1;
      ex = ex + 1;
    end
    while (!s[12]) begin
      s  = s << 1;
      ex = ex - 1;
    end
    return {x[15], 6'(ex), s[11:3]};
  endfunction

  assign add_sum  = dl_add(add_a, add_b);
  assign add_sum2 = dl_add(add_a2, add_b2);

  dlfloat16_vec_acc #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  dlfloat16_vec_acc #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one element and wait (bounded) for its handshake; in_valid is left asserted.
  task automatic send(input logic [15:0] d, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      tick();
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_add_a"},     32'(add_a),     32'd0);
    chk({tag, "_add_b"},     32'(add_b),     32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    chk_reset_outputs("rst0");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Four ones back-to-back -> 4.0, two cycles from last handshake to out_valid.
    for (int i = 0; i < 4; i++) send(16'h3E00, i == 3);
    in_valid = 1'b0;
    chk("t1_flush_in_ready",  32'(in_ready),  32'd0);
    chk("t1_flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_in_ready",  32'(in_ready),  32'd0);
    chk("t1_out_data",  32'(out_data),  32'h4200);
    chk("t1_out_count", 32'(out_count), 32'd4);
    tick();
    chk("t1_consumed", 32'(out_valid), 32'd0);

    // Single element: result one cycle later, seeded value unchanged.
    send(16'hC100, 1'b1);
    in_valid = 1'b0;
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_data",  32'(out_data),  32'hC100);
    chk("t2_out_count", 32'(out_count), 32'd1);
    tick();

    // Output stall with an element pending on the input.
    out_ready = 1'b0;
    send(16'h4000, 1'b0);
    send(16'h3E00, 1'b1);
    in_data = 16'h4400;
    in_last = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_rdy",   32'(in_ready),  32'd0);
      chk("t3_hold_data",  32'(out_data),  32'h4100);
      chk("t3_hold_count", 32'(out_count), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_after_hs_valid", 32'(out_valid), 32'd0);
    chk("t3_after_hs_rdy",   32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_pending_valid", 32'(out_valid), 32'd1);
    chk("t3_pending_data",  32'(out_data),  32'h4400);
    chk("t3_pending_count", 32'(out_count), 32'd1);
    tick();

    // Flush mid-vector; the beat presented with flush is dropped.
    send(16'h3E00, 1'b0);
    send(16'h3E00, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h4400; in_last = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_flush_count", 32'(out_count), 32'd0);
    chk("t4_flush_valid", 32'(out_valid), 32'd0);
    chk("t4_flush_rdy",   32'(in_ready),  32'd1);
    send(16'h4000, 1'b0);
    send(16'h3E00, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("t4_out_valid", 32'(out_valid), 32'd1);
    chk("t4_out_data",  32'(out_data),  32'h4100);
    chk("t4_out_count", 32'(out_count), 32'd2);
    tick();

    // Five ones: 5.0; narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) send(16'h3E00, i == 4);
    in_valid = 1'b0;
    tick();
    chk("t5_out_valid",  32'(out_valid),  32'd1);
    chk("t5_out_data",   32'(out_data),   32'h4280);
    chk("t5_out_count",  32'(out_count),  32'd5);
    chk("t5_out_valid2", 32'(out_valid2), 32'd1);
    chk("t5_out_data2",  32'(out_data2),  32'h4280);
    chk("t5_out_count2", 32'(out_count2), 32'd3);
    tick();

    // Asynchronous reset between edges while accumulating.
    send(16'h3E00, 1'b0);
    send(16'h3E00, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("t6_async");
    #1 rst = 1'b0;
    tick();
    send(16'h4000, 1'b0);
    send(16'h3E00, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_out_data",  32'(out_data),  32'h4100);
    chk("t6_out_count", 32'(out_count), 32'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dlfloat16_vec_acc.md
# dlfloat16_vec_acc

Streaming reduction stage that sums a vector of DLFloat16 elements (1 sign, 6-bit exponent, 9-bit mantissa) into a single DLFloat16 result. It sits directly upstream of the combinational `dlfloat16_add` adder: it drives the adder's two operands from registers and captures the adder's sum on the next clock edge. The result is returned on a valid/ready output port. The adder is instantiated beside this block and wired port-to-port; it is not embedded inside it.

## Interface
- `CNT_W`, default 8: width of the element counter; the count saturates at 2^CNT_W-1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous abort of the vector in progress.
- `in_valid`  in  1  element valid.
- `in_ready`  out  1  element accepted on `in_valid & in_ready`.
- `in_data`  in  16  DLFloat16 element.
- `in_last`  in  1  marks the final element of a vector; sampled on the handshake.
- `add_a`  out  16  adder operand a, equal to `acc_q`.
- `add_b`  out  16  adder operand b, equal to `opnd_q`.
- `add_sum`  in  16  adder result `c_add_1`, combinational from `add_a`/`add_b`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed on `out_valid & out_ready`.
- `out_data`  out  16  accumulated sum, equal to `acc_q`.
- `out_count`  out  CNT_W  number of elements in the vector, saturating.

## Operation
- Registers: `acc_q[15:0]`, `opnd_q[15:0]`, `opnd_vld`, `cnt_q[CNT_W-1:0]`, and a state register.
- State encoding:
  - EMPTY: no element of the current vector has been taken yet.
  - ACC: the accumulator is seeded and further elements are being added.
  - FLUSH: the last element is held in `opnd_q` and has not yet been added.
  - HOLD: the result is presented on the output port.
- `in_ready` = (state==EMPTY) | (state==ACC). It is a decode of state only and never depends on `in_valid`.
- `out_valid` = (state==HOLD).
- EMPTY, on handshake:
  - The first element seeds the accumulator: `acc_q`<=`in_data`, `cnt_q`<=1, with no addition.
  - Seeding is mandatory. The adder mishandles a zero-exponent operand, so the block must never add to 0x0000.
  - If `in_last`, next state is HOLD; otherwise ACC.
- ACC, every cycle: if `opnd_vld`, then `acc_q`<=`add_sum` and `opnd_vld`<=0, unless it is reloaded in the same cycle.
- ACC, on handshake:
  - `opnd_q`<=`in_data`, `opnd_vld`<=1, `cnt_q`<=sat(`cnt_q`+1).
  - Accepting a new element and folding the previous operand happen in the same cycle, giving one element per cycle.
  - If `in_last`, next state is FLUSH.
- FLUSH: `acc_q`<=`add_sum`, `opnd_vld`<=0, next state HOLD.
- HOLD:
  - `out_data`/`out_count` are held stable until `out_ready`.
  - On the output handshake: next state EMPTY, `cnt_q`<=0, `opnd_vld`<=0.
  - No element is accepted in the same cycle as the output handshake.
- `flush` (any state): next state EMPTY, `cnt_q`<=0, `opnd_vld`<=0. It overrides both handshakes in that cycle; a beat presented that cycle is dropped. `acc_q` is left unchanged.
- Special values need no handling here. NaN/Inf (0xFFFF) and the saturated results (0x7DFE/0xFDFE, 0x0201/0x8201) come from the adder and propagate through `acc_q`.
- The addition order is strictly arrival order. Results are not reassociated.

## Timing
- Reset values (immediate on `rst`, no clock needed):
  - state EMPTY; `acc_q`, `opnd_q`, `cnt_q` = 0; `opnd_vld` = 0.
  - Outputs: `out_valid`=0, `in_ready`=1, `add_a`=`add_b`=0, `out_data`=0, `out_count`=0.
- No handshake is honoured while `rst` is high.
- Latency from the last-element handshake at edge t to `out_valid` high:
  - single-element vector: after edge t, i.e. 1 cycle;
  - multi-element vector: after edge t+1, i.e. 2 cycles.
- Throughput:
  - 1 element per cycle inside a vector;
  - `in_ready` is low for 1 cycle in FLUSH, plus every cycle spent in HOLD.
- There is exactly one adder evaluation per cycle. The critical path is `acc_q`/`opnd_q` -> adder -> `acc_q`.
- Counter saturation: with `cnt_q` = 2^CNT_W-1, further elements are still summed and `cnt_q` stays at its maximum.

## Test plan
In every scenario the bench wires a real `dlfloat16_add` to `add_a`/`add_b`/`add_sum`.
- Input {0x3E00, 0x3E00, 0x3E00, 0x3E00 (last)} back-to-back, `out_ready`=1.
  - Required: `out_data`=0x4200 (4.0), `out_count`=4.
  - `out_valid` rises 2 cycles after the last handshake; `in_ready` is 0 in FLUSH and HOLD.
- Input a single element 0xC100 (-3.0) with `in_last`.
  - Required: `out_valid` 1 cycle later, `out_data`=0xC100, `out_count`=1, and no adder result is used.
- Input {0x4000, 0x3E00 (last)}, then hold `out_ready`=0 for 5 cycles while `in_valid` stays 1.
  - Required: `out_data`=0x4100 is stable with `out_valid`=1, `in_ready`=0, and no element is consumed.
  - After `out_ready` is asserted, the pending element is accepted one cycle after the output handshake.
- Send 2 elements of 0x3E00, then pulse `flush`, then send {0x4000, 0x3E00 (last)}.
  - Required: `out_data`=0x4100, `out_count`=2.
- With CNT_W=2, send 5 elements of 0x3E00.
  - Required: `out_data`=0x4280 (5.0) and `out_count`=3, i.e. saturated.
- Assert `rst` asynchronously mid-ACC.
  - Required: all outputs reach their reset values before the next clock edge, and the next vector accumulates correctly.
